// File: rtl/tx_frame_scheduler_pkg.sv
// Shared definitions for the TX frame scheduler: header layout, state encoding, defaults.
package tx_frame_scheduler_pkg;

    // Header layout in 16-bit words: len, ts[63:48]..ts[15:0], hash_hi, hash_lo
    localparam int unsigned OFF_LEN   = 0;
    localparam int unsigned OFF_TS    = 1;
    localparam int unsigned OFF_HASH  = 5;
    localparam int unsigned HDR_WORDS = OFF_HASH + 2;

    localparam logic [15:0] MAX_FRAME_LEN_DEF = 16'd1514;
    localparam logic [31:0] LATE_TOL_DEF      = 32'd125;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_REL
    } sched_state_t;

    // Slot footprint of one frame: header plus payload rounded up to whole words
    function automatic logic [15:0] frame_words(input logic [15:0] len);
        return 16'(HDR_WORDS) + 16'((17'(len) + 17'd1) >> 1);
    endfunction

endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Slot-memory read port and pointer exchange between the scheduler and the memory/sender side.
interface tx_frame_scheduler_if #(
    parameter int unsigned ADDR_W = 14
);
    logic [ADDR_W-1:0] mem_wr_ptr_in;
    logic [ADDR_W-1:0] sched_addr;
    logic [15:0]       sched_q;
    logic [ADDR_W-1:0] sched_wr_ptr;

    modport master (
        input  mem_wr_ptr_in,
        input  sched_q,
        output sched_addr,
        output sched_wr_ptr
    );

    modport slave (
        output mem_wr_ptr_in,
        output sched_q,
        input  sched_addr,
        input  sched_wr_ptr
    );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Timestamp-gated release of fully written TX frames: fetches each header, waits for data
// and (optionally) its launch time, then advances the pointer seen by the GMII sender.
module tx_frame_scheduler
    import tx_frame_scheduler_pkg::*;
#(
    parameter int unsigned ADDR_W        = 14,
    parameter logic [15:0] MAX_FRAME_LEN = MAX_FRAME_LEN_DEF,
    parameter logic [31:0] LATE_TOL      = LATE_TOL_DEF
) (
    input  logic                        gmii_tx_clk,
    input  logic                        sys_rst,
    input  logic [63:0]                 global_counter,
    input  logic                        enable,
    input  logic                        ts_mode,
    tx_frame_scheduler_if.master        mem_if,
    output logic [31:0]                 frame_count,
    output logic [15:0]                 late_count,
    output logic                        len_err,
    output logic                        busy
);

    sched_state_t      state;
    logic [2:0]        hdr_cnt;
    logic [15:0]       len;
    logic [63:0]       ts;
    logic              first_wait;
    logic              late_flag;

    logic [ADDR_W-1:0] avail;
    logic [ADDR_W-1:0] foot;
    logic              ts_ok;
    logic              late_now;

    assign avail = mem_if.mem_wr_ptr_in - mem_if.sched_wr_ptr;
    assign foot  = ADDR_W'(frame_words(len));
    assign ts_ok = !ts_mode || (ts == '0) || (global_counter >= ts);
    // Difference form avoids overflow of ts + LATE_TOL near the top of the time base
    assign late_now = ts_mode && (ts != '0) && (global_counter > ts) &&
                      ((global_counter - ts) > 64'(LATE_TOL));
    assign busy  = (state != S_IDLE);

    always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state               <= S_IDLE;
            hdr_cnt             <= '0;
            len                 <= '0;
            ts                  <= '0;
            first_wait          <= 1'b0;
            late_flag           <= 1'b0;
            mem_if.sched_addr   <= '0;
            mem_if.sched_wr_ptr <= '0;
            frame_count         <= '0;
            late_count          <= '0;
            len_err             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && !len_err && avail >= ADDR_W'(HDR_WORDS)) begin
                        state             <= S_HDR;
                        hdr_cnt           <= '0;
                        mem_if.sched_addr <= mem_if.sched_wr_ptr;
                    end
                end
                // Address k is issued in count k; its data is captured in count k+1
                S_HDR: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        hdr_cnt <= hdr_cnt + 3'd1;
                        if (hdr_cnt < 3'(OFF_TS + 3))
                            mem_if.sched_addr <= mem_if.sched_addr + ADDR_W'(1);
                        case (hdr_cnt)
                            3'(OFF_LEN + 1): len          <= mem_if.sched_q;
                            3'(OFF_TS + 1):  ts[63:48]    <= mem_if.sched_q;
                            3'(OFF_TS + 2):  ts[47:32]    <= mem_if.sched_q;
                            3'(OFF_TS + 3):  ts[31:16]    <= mem_if.sched_q;
                            3'(OFF_TS + 4): begin
                                ts[15:0] <= mem_if.sched_q;
                                if (len == '0 || len > MAX_FRAME_LEN) begin
                                    len_err <= 1'b1;
                                    state   <= S_IDLE;
                                end else begin
                                    first_wait <= 1'b1;
                                    late_flag  <= 1'b0;
                                    state      <= S_WAIT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else begin
                        first_wait <= 1'b0;
                        if (first_wait)
                            late_flag <= late_now;
                        if (avail >= foot && ts_ok)
                            state <= S_REL;
                    end
                end
                S_REL: begin
                    mem_if.sched_wr_ptr <= mem_if.sched_wr_ptr + foot;
                    frame_count         <= frame_count + 32'd1;
                    if (late_flag && late_count != '1)
                        late_count <= late_count + 16'd1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with a behavioural slot memory (1-cycle read latency).
module tb_tx_frame_scheduler;

    logic        gmii_tx_clk = 1'b0;
    logic        sys_rst;
    logic [63:0] global_counter;
    logic        enable;
    logic        ts_mode;
    logic [31:0] frame_count;
    logic [15:0] late_count;
    logic        len_err;
    logic        busy;

    logic [15:0] mem [0:16383];

    int checks = 0;
    int passes = 0;

    tx_frame_scheduler_if #(.ADDR_W(14)) mem_if ();

    tx_frame_scheduler #(
        .ADDR_W        (14),
        .MAX_FRAME_LEN (16'd1514),
        .LATE_TOL      (32'd125)
    ) dut (
        .gmii_tx_clk    (gmii_tx_clk),
        .sys_rst        (sys_rst),
        .global_counter (global_counter),
        .enable         (enable),
        .ts_mode        (ts_mode),
        .mem_if         (mem_if.master),
        .frame_count    (frame_count),
        .late_count     (late_count),
        .len_err        (len_err),
        .busy           (busy)
    );

    always #5 gmii_tx_clk = ~gmii_tx_clk;

    always @(posedge gmii_tx_clk) mem_if.sched_q <= mem[mem_if.sched_addr];

    task automatic tick();
        @(posedge gmii_tx_clk);
        #1;
    endtask

    task automatic write_frame(input logic [13:0] head, input logic [15:0] flen,
                               input logic [63:0] fts);
        logic [15:0] w [7];
        w[0] = flen;
        w[1] = fts[63:48];
        w[2] = fts[47:32];
        w[3] = fts[31:16];
        w[4] = fts[15:0];
        w[5] = 16'hA5A5;
        w[6] = 16'h5A5A;
        for (int i = 0; i < 7; i++) mem[head + 14'(i)] = w[i];
    endtask

    task automatic wait_ptr(input int max_cyc, output int n);
        logic [13:0] old;
        old = mem_if.sched_wr_ptr;
        n = 0;
        while (mem_if.sched_wr_ptr === old && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        sys_rst              = 1'b1;
        enable               = 1'b0;
        ts_mode              = 1'b0;
        global_counter       = '0;
        mem_if.mem_wr_ptr_in = '0;
        repeat (2) tick();
        @(negedge gmii_tx_clk);
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        sys_rst              = 1'b1;
        enable               = 1'b0;
        ts_mode              = 1'b0;
        global_counter       = '0;
        mem_if.mem_wr_ptr_in = '0;
        repeat (2) tick();
        checks++; if (mem_if.sched_wr_ptr !== 14'd0) $display("FAIL rst_ptr: got %0d expected 0", mem_if.sched_wr_ptr); else passes++;
        checks++; if (mem_if.sched_addr !== 14'd0) $display("FAIL rst_addr: got %0d expected 0", mem_if.sched_addr); else passes++;
        checks++; if (frame_count !== 32'd0) $display("FAIL rst_frames: got %0d expected 0", frame_count); else passes++;
        checks++; if (late_count !== 16'd0) $display("FAIL rst_late: got %0d expected 0", late_count); else passes++;
        checks++; if (len_err !== 1'b0) $display("FAIL rst_len_err: got %b expected 0", len_err); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passes++;
        @(negedge gmii_tx_clk);
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_untimed();
        int n;
        ts_mode = 1'b0;
        write_frame(14'd0, 16'd60, 64'd0);
        enable = 1'b1;
        mem_if.mem_wr_ptr_in = 14'd37;
        wait_ptr(30, n);
        checks++; if (n !== 9) $display("FAIL t1_latency: got %0d cycles expected 9", n); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd37) $display("FAIL t1_ptr: got %0d expected 37", mem_if.sched_wr_ptr); else passes++;
        checks++; if (frame_count !== 32'd1) $display("FAIL t1_frames: got %0d expected 1", frame_count); else passes++;
    endtask

    task automatic test_ts_gate();
        int n;
        ts_mode = 1'b1;
        global_counter = 64'd900;
        write_frame(14'd37, 16'd60, 64'd1000);
        mem_if.mem_wr_ptr_in = 14'd74;
        repeat (20) tick();
        checks++; if (mem_if.sched_wr_ptr !== 14'd37) $display("FAIL t2_hold: got %0d expected 37", mem_if.sched_wr_ptr); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL t2_busy: got %b expected 1", busy); else passes++;
        global_counter = 64'd999;
        repeat (5) tick();
        checks++; if (mem_if.sched_wr_ptr !== 14'd37) $display("FAIL t2_hold999: got %0d expected 37", mem_if.sched_wr_ptr); else passes++;
        global_counter = 64'd1000;
        wait_ptr(20, n);
        checks++; if (n !== 2) $display("FAIL t2_latency: got %0d cycles expected 2", n); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd74) $display("FAIL t2_ptr: got %0d expected 74", mem_if.sched_wr_ptr); else passes++;
        checks++; if (late_count !== 16'd0) $display("FAIL t2_late: got %0d expected 0", late_count); else passes++;
        checks++; if (frame_count !== 32'd2) $display("FAIL t2_frames: got %0d expected 2", frame_count); else passes++;
    endtask

    task automatic test_late();
        int n;
        ts_mode = 1'b1;
        global_counter = 64'd500;
        write_frame(14'd74, 16'd60, 64'd100);
        mem_if.mem_wr_ptr_in = 14'd111;
        wait_ptr(30, n);
        checks++; if (mem_if.sched_wr_ptr !== 14'd111) $display("FAIL t3_ptr: got %0d expected 111", mem_if.sched_wr_ptr); else passes++;
        checks++; if (late_count !== 16'd1) $display("FAIL t3_late: got %0d expected 1", late_count); else passes++;
        global_counter = 64'd225;
        write_frame(14'd111, 16'd60, 64'd100);
        mem_if.mem_wr_ptr_in = 14'd148;
        wait_ptr(30, n);
        checks++; if (mem_if.sched_wr_ptr !== 14'd148) $display("FAIL t3_edge_ptr: got %0d expected 148", mem_if.sched_wr_ptr); else passes++;
        checks++; if (late_count !== 16'd1) $display("FAIL t3_edge_late: got %0d expected 1", late_count); else passes++;
        global_counter = 64'd226;
        write_frame(14'd148, 16'd60, 64'd100);
        mem_if.mem_wr_ptr_in = 14'd185;
        wait_ptr(30, n);
        checks++; if (late_count !== 16'd2) $display("FAIL t3_over_late: got %0d expected 2", late_count); else passes++;
        checks++; if (frame_count !== 32'd5) $display("FAIL t3_frames: got %0d expected 5", frame_count); else passes++;
    endtask

    task automatic test_enable_abort();
        int n;
        ts_mode = 1'b1;
        global_counter = 64'd100;
        write_frame(14'd185, 16'd60, 64'd5000);
        mem_if.mem_wr_ptr_in = 14'd222;
        repeat (15) tick();
        checks++; if (busy !== 1'b1) $display("FAIL t6_busy: got %b expected 1", busy); else passes++;
        global_counter = 64'd5000;
        enable = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL t6_abort_idle: got %b expected 0", busy); else passes++;
        repeat (10) tick();
        checks++; if (mem_if.sched_wr_ptr !== 14'd185) $display("FAIL t6_hold: got %0d expected 185", mem_if.sched_wr_ptr); else passes++;
        checks++; if (frame_count !== 32'd5) $display("FAIL t6_frames_low: got %0d expected 5", frame_count); else passes++;
        enable = 1'b1;
        wait_ptr(30, n);
        checks++; if (n !== 9) $display("FAIL t6_refetch: got %0d cycles expected 9", n); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd222) $display("FAIL t6_ptr: got %0d expected 222", mem_if.sched_wr_ptr); else passes++;
        checks++; if (frame_count !== 32'd6) $display("FAIL t6_frames: got %0d expected 6", frame_count); else passes++;
        checks++; if (late_count !== 16'd2) $display("FAIL t6_late: got %0d expected 2", late_count); else passes++;
    endtask

    task automatic test_wrap();
        int n;
        int cur;
        int r;
        int f;
        int nf;
        ts_mode = 1'b0;
        cur = 222;
        nf = 0;
        for (int it = 0; it < 40 && cur != 16380; it++) begin
            r = 16380 - cur;
            f = (r >= 764) ? 764 : r;
            if (r - f > 0 && r - f < 8) f = r - 8;
            write_frame(14'(cur), 16'(2 * (f - 7)), 64'd0);
            mem_if.mem_wr_ptr_in = 14'(cur + f);
            wait_ptr(60, n);
            checks++; if (mem_if.sched_wr_ptr !== 14'(cur + f)) $display("FAIL t4_bulk_ptr: got %0d expected %0d", mem_if.sched_wr_ptr, cur + f); else passes++;
            cur = cur + f;
            nf++;
        end
        checks++; if (frame_count !== 32'(6 + nf)) $display("FAIL t4_bulk_frames: got %0d expected %0d", frame_count, 6 + nf); else passes++;
        write_frame(14'd16380, 16'd64, 64'd0);
        mem_if.mem_wr_ptr_in = 14'd34;
        repeat (30) tick();
        checks++; if (mem_if.sched_wr_ptr !== 14'd16380) $display("FAIL t4_hold: got %0d expected 16380", mem_if.sched_wr_ptr); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL t4_busy: got %b expected 1", busy); else passes++;
        mem_if.mem_wr_ptr_in = 14'd35;
        wait_ptr(20, n);
        checks++; if (n !== 2) $display("FAIL t4_latency: got %0d cycles expected 2", n); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd35) $display("FAIL t4_wrap_ptr: got %0d expected 35", mem_if.sched_wr_ptr); else passes++;
        checks++; if (frame_count !== 32'(7 + nf)) $display("FAIL t4_frames: got %0d expected %0d", frame_count, 7 + nf); else passes++;
    endtask

    task automatic test_len_err();
        logic [31:0] fc;
        fc = frame_count;
        ts_mode = 1'b0;
        write_frame(14'd35, 16'd0, 64'd0);
        mem_if.mem_wr_ptr_in = 14'd85;
        repeat (20) tick();
        checks++; if (len_err !== 1'b1) $display("FAIL t5_len0_err: got %b expected 1", len_err); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd35) $display("FAIL t5_len0_ptr: got %0d expected 35", mem_if.sched_wr_ptr); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL t5_len0_busy: got %b expected 0", busy); else passes++;
        write_frame(14'd35, 16'd60, 64'd0);
        repeat (20) tick();
        checks++; if (mem_if.sched_wr_ptr !== 14'd35) $display("FAIL t5_halted_ptr: got %0d expected 35", mem_if.sched_wr_ptr); else passes++;
        checks++; if (frame_count !== fc) $display("FAIL t5_halted_frames: got %0d expected %0d", frame_count, fc); else passes++;

        do_reset();
        checks++; if (len_err !== 1'b0) $display("FAIL t5_rst_err: got %b expected 0", len_err); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd0) $display("FAIL t5_rst_ptr: got %0d expected 0", mem_if.sched_wr_ptr); else passes++;
        write_frame(14'd0, 16'd2000, 64'd0);
        enable = 1'b1;
        mem_if.mem_wr_ptr_in = 14'd1100;
        repeat (20) tick();
        checks++; if (len_err !== 1'b1) $display("FAIL t5_len2000_err: got %b expected 1", len_err); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd0) $display("FAIL t5_len2000_ptr: got %0d expected 0", mem_if.sched_wr_ptr); else passes++;
        checks++; if (frame_count !== 32'd0) $display("FAIL t5_len2000_frames: got %0d expected 0", frame_count); else passes++;

        do_reset();
        write_frame(14'd0, 16'd1515, 64'd0);
        enable = 1'b1;
        mem_if.mem_wr_ptr_in = 14'd800;
        repeat (20) tick();
        checks++; if (len_err !== 1'b1) $display("FAIL t5_len1515_err: got %b expected 1", len_err); else passes++;
        checks++; if (mem_if.sched_wr_ptr !== 14'd0) $display("FAIL t5_len1515_ptr: got %0d expected 0", mem_if.sched_wr_ptr); else passes++;
    endtask

    initial begin
        test_reset();
        test_untimed();
        test_ts_gate();
        test_late();
        test_enable_abort();
        test_wrap();
        test_len_err();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
